// File: rtl/layer_pkg.sv
// Shared types and helpers for the inter-layer stream transmitter.
package layer_pkg;

  localparam int unsigned DefDataSize = 8;
  localparam int unsigned DefChannels = 256;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRdy,
    StStream,
    StDrain,
    StStart
  } tx_state_t;

  // Default-geometry pixel; modules build the same shape from their own parameters.
  typedef logic [DefChannels-1:0][DefDataSize-1:0] pixel_t;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/frame_buf.sv
// Frame store: one write port, one synchronous read port with a registered output.
// i_clr loads zero into the output register instead of reading the array.
module frame_buf #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CHANNELS  = 256,
  parameter int unsigned DEPTH     = 169,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_we,
  input  logic [ADDR_W-1:0]                  i_waddr,
  input  logic [CHANNELS-1:0][DATA_SIZE-1:0] i_wdata,
  input  logic                               i_re,
  input  logic                               i_clr,
  input  logic [ADDR_W-1:0]                  i_raddr,
  output logic [CHANNELS-1:0][DATA_SIZE-1:0] o_rdata
);

  typedef logic [CHANNELS-1:0][DATA_SIZE-1:0] word_t;

  word_t mem [DEPTH];
  word_t rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (i_clr) begin
      rdata_d = '0;
    end else if (i_re) begin
      rdata_d = mem[i_raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/layer_stream_tx.sv
// Head-of-chain frame transmitter: buffers one frame, streams it one pixel per cycle, then
// pulses start. Define STREAM_PAD_EN to emit a PAD-wide zero border around the frame.
module layer_stream_tx
  import layer_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CHANNELS  = 256,
  parameter int unsigned IMG_DIM   = 13,
  parameter int unsigned PAD       = 1,
  localparam int unsigned ADDR_W   = addr_width(IMG_DIM * IMG_DIM)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_load_we,
  input  logic [ADDR_W-1:0]                  i_load_addr,
  input  logic [CHANNELS-1:0][DATA_SIZE-1:0] i_load_data,
  input  logic                               i_go,
  output logic                               o_ready,
  input  logic                               i_next_ready,
  output logic [CHANNELS-1:0][DATA_SIZE-1:0] o_next_data,
  output logic [CHANNELS-1:0]                o_next_we,
  output logic                               o_next_start
);

  localparam int unsigned NPix = IMG_DIM * IMG_DIM;

  // A border wider than the frame itself is almost certainly a misconfiguration.
  if (PAD > IMG_DIM) begin : g_pad_check
    $error("PAD exceeds IMG_DIM");
  end

  tx_state_t         state_q, state_d;
  logic              we_q, we_d;
  logic              start_q, start_d;
  logic              buf_we;
  logic              rd_en, rd_clr;
  logic [ADDR_W-1:0] rd_addr;
  logic              last_beat;

  assign buf_we = (state_q == StIdle) && i_load_we && (32'(i_load_addr) < NPix);

`ifdef STREAM_PAD_EN
  localparam int unsigned    PDim = IMG_DIM + 2 * PAD;
  localparam int unsigned    CntW = addr_width(PDim);
  localparam logic [CntW-1:0] Lo  = CntW'(PAD);
  localparam logic [CntW-1:0] Hi  = CntW'(PAD + IMG_DIM);
  localparam logic [CntW-1:0] Max = CntW'(PDim - 1);

  logic [CntW-1:0] row_q, row_d, col_q, col_d;
  logic            interior;

  always_comb begin
    interior  = (row_q >= Lo) && (row_q < Hi) && (col_q >= Lo) && (col_q < Hi);
    last_beat = (row_q == Max) && (col_q == Max);
    rd_addr   = ADDR_W'((32'(row_q) - PAD) * IMG_DIM + 32'(col_q) - PAD);
    rd_en     = (state_q == StStream) && interior;
    // Border beats zero the output register rather than reading the buffer.
    rd_clr    = (state_q == StStream) && !interior;
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (state_q != StStream) begin
      row_d = '0;
      col_d = '0;
    end else if (col_q == Max) begin
      col_d = '0;
      row_d = last_beat ? '0 : row_q + 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
`else
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    last_beat = (cnt_q == ADDR_W'(NPix - 1));
    cnt_d     = ((state_q == StStream) && !last_beat) ? cnt_q + 1'b1 : '0;
    rd_addr   = cnt_q;
    rd_en     = (state_q == StStream);
    rd_clr    = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // we_q trails STREAM by one cycle to line up with the registered read data.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_go) begin
          state_d = i_next_ready ? StStream : StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (i_next_ready) begin
          state_d = StStream;
        end
      end
      StStream: begin
        we_d = 1'b1;
        if (last_beat) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        start_d = 1'b1;
        state_d = StStart;
      end
      StStart: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      start_q <= start_d;
    end
  end

  frame_buf #(
    .DATA_SIZE (DATA_SIZE),
    .CHANNELS  (CHANNELS),
    .DEPTH     (NPix),
    .ADDR_W    (ADDR_W)
  ) u_frame_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (buf_we),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_data),
    .i_re    (rd_en),
    .i_clr   (rd_clr),
    .i_raddr (rd_addr),
    .o_rdata (o_next_data)
  );

  assign o_ready      = (state_q == StIdle);
  assign o_next_we    = {CHANNELS{we_q}};
  assign o_next_start = start_q;

endmodule

// File: tb/tb_layer_stream_tx.sv
// Directed bench for layer_stream_tx at IMG_DIM=3, CHANNELS=2; follows STREAM_PAD_EN if defined.
`timescale 1ns/1ps
module tb_layer_stream_tx;

  localparam int unsigned DW   = 8;
  localparam int unsigned CH   = 2;
  localparam int unsigned DIM  = 3;
  localparam int unsigned PADW = 1;
  localparam int unsigned AW   = 4;
`ifdef STREAM_PAD_EN
  localparam int NB = (DIM + 2 * PADW) * (DIM + 2 * PADW);
`else
  localparam int NB = DIM * DIM;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   load_we;
  logic [AW-1:0]          load_addr;
  logic [CH-1:0][DW-1:0]  load_data;
  logic                   go;
  logic                   ready;
  logic                   next_ready;
  logic [CH-1:0][DW-1:0]  next_data;
  logic [CH-1:0]          next_we;
  logic                   next_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bad_we = 0;
  logic [15:0] img [9];
  logic [15:0] beat_q [$];
  int          beat_cyc [$];
  int          start_cyc [$];

  always #5 clk = ~clk;

  layer_stream_tx #(
    .DATA_SIZE (DW),
    .CHANNELS  (CH),
    .IMG_DIM   (DIM),
    .PAD       (PADW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_load_we    (load_we),
    .i_load_addr  (load_addr),
    .i_load_data  (load_data),
    .i_go         (go),
    .o_ready      (ready),
    .i_next_ready (next_ready),
    .o_next_data  (next_data),
    .o_next_we    (next_we),
    .o_next_start (next_start)
  );

  function automatic logic [15:0] exp_beat(input int b);
`ifdef STREAM_PAD_EN
    int pd;
    int r;
    int c;
    pd = DIM + 2 * PADW;
    r  = b / pd;
    c  = b % pd;
    if (r >= 1 && r <= 3 && c >= 1 && c <= 3) return img[(r - 1) * 3 + (c - 1)];
    return 16'h0000;
`else
    return img[b];
`endif
  endfunction

  // Advance to the next falling edge and log what the DUT presents there.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (next_we == 2'b11) begin
      beat_q.push_back(next_data);
      beat_cyc.push_back(cyc);
    end else if (next_we !== 2'b00) begin
      bad_we++;
    end
    if (next_start === 1'b1) start_cyc.push_back(cyc);
  endtask

  task automatic clear_log();
    beat_q.delete();
    beat_cyc.delete();
    start_cyc.delete();
    bad_we = 0;
  endtask

  task automatic load_pixel(input int addr, input logic [15:0] data);
    load_we   = 1'b1;
    load_addr = AW'(addr);
    load_data = data;
    step();
    load_we   = 1'b0;
  endtask

  task automatic load_frame();
    for (int k = 0; k < 9; k++) begin
      img[k] = {8'(k), 8'(8'h80 + k)};
      load_pixel(k, img[k]);
    end
  endtask

  task automatic start_stream(input logic nr, output int c);
    go         = 1'b1;
    next_ready = nr;
    c          = cyc;
    step();
    go         = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (ready === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    go         = 1'b0;
    load_we    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    next_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", ready);
    end
    checks++;
    if (next_we !== 2'b00) begin
      errors++; $display("FAIL reset_we: got %b expected 00", next_we);
    end
    checks++;
    if (next_start !== 1'b0) begin
      errors++; $display("FAIL reset_start: got %b expected 0", next_start);
    end
    checks++;
    if (next_data !== 16'h0000) begin
      errors++; $display("FAIL reset_data: got %h expected 0000", next_data);
    end
  endtask

  task automatic test_basic_stream();
    int c;
    int at;
    int bad;
    load_frame();
    clear_log();
    start_stream(1'b1, c);
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL basic_busy: got ready=%b expected 0", ready);
    end
    wait_ready(NB + 20, at);
    checks++;
    if (at != c + NB + 3) begin
      errors++; $display("FAIL basic_ready_at: got %0d expected %0d", at, c + NB + 3);
    end
    checks++;
    if (beat_q.size() != NB) begin
      errors++; $display("FAIL basic_count: got %0d expected %0d", beat_q.size(), NB);
    end
    checks++;
    if (beat_cyc.size() == 0 || beat_cyc[0] != c + 2) begin
      errors++; $display("FAIL basic_first_beat: got %0d expected %0d",
                         beat_cyc.size() > 0 ? beat_cyc[0] : -1, c + 2);
    end
    checks++;
    if (beat_cyc.size() != NB || beat_cyc[NB - 1] != c + NB + 1) begin
      errors++; $display("FAIL basic_last_beat: got %0d expected %0d",
                         beat_cyc.size() == NB ? beat_cyc[NB - 1] : -1, c + NB + 1);
    end
    checks++;
    if (start_cyc.size() != 1 || start_cyc[0] != c + NB + 2) begin
      errors++; $display("FAIL basic_start: got %0d pulses first at %0d expected 1 at %0d",
                         start_cyc.size(), start_cyc.size() > 0 ? start_cyc[0] : -1, c + NB + 2);
    end
    bad = 0;
    for (int b = 0; b < beat_q.size() && b < NB; b++) begin
      if (beat_q[b] !== exp_beat(b)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL basic_data: got %0d bad beats expected 0", bad);
    end
    checks++;
    if (bad_we != 0) begin
      errors++; $display("FAIL basic_we_mask: got %0d partial masks expected 0", bad_we);
    end
  endtask

  task automatic test_same_cycle_load_go();
    int at;
    int bad;
    logic [15:0] orig;
    orig = img[0];
    clear_log();
    img[0]     = 16'h1234;
    load_we    = 1'b1;
    load_addr  = '0;
    load_data  = 16'h1234;
    go         = 1'b1;
    next_ready = 1'b1;
    step();
    load_we = 1'b0;
    go      = 1'b0;
    wait_ready(NB + 20, at);
    bad = 0;
    for (int b = 0; b < beat_q.size() && b < NB; b++) begin
      if (beat_q[b] !== exp_beat(b)) bad++;
    end
    checks++;
    if (beat_q.size() != NB || bad != 0) begin
      errors++; $display("FAIL same_cycle_load_go: got %0d beats %0d bad expected %0d beats 0 bad",
                         beat_q.size(), bad, NB);
    end
    img[0] = orig;
    load_pixel(0, orig);
  endtask

  task automatic test_wait_ready();
    int c;
    int r;
    int at;
    int rdy_hi;
    clear_log();
    start_stream(1'b0, c);
    rdy_hi = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ready !== 1'b0) rdy_hi++;
    end
    checks++;
    if (beat_q.size() != 0 || rdy_hi != 0) begin
      errors++; $display("FAIL wait_idle: got %0d beats, ready high %0d cycles expected 0 and 0",
                         beat_q.size(), rdy_hi);
    end
    r          = cyc;
    next_ready = 1'b1;
    wait_ready(NB + 20, at);
    checks++;
    if (beat_cyc.size() == 0 || beat_cyc[0] != r + 2) begin
      errors++; $display("FAIL wait_first_beat: got %0d expected %0d",
                         beat_cyc.size() > 0 ? beat_cyc[0] : -1, r + 2);
    end
    checks++;
    if (beat_q.size() != NB || start_cyc.size() != 1) begin
      errors++; $display("FAIL wait_count: got %0d beats %0d starts expected %0d beats 1 start",
                         beat_q.size(), start_cyc.size(), NB);
    end
  endtask

  task automatic test_load_during_stream();
    int c;
    int at;
    int bad;
    clear_log();
    start_stream(1'b1, c);
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL lds_busy: got ready=%b expected 0", ready);
    end
    load_pixel(4, 16'hFFFF);
    wait_ready(NB + 20, at);
    clear_log();
    start_stream(1'b1, c);
    wait_ready(NB + 20, at);
    bad = 0;
    for (int b = 0; b < beat_q.size() && b < NB; b++) begin
      if (beat_q[b] !== exp_beat(b)) bad++;
    end
    checks++;
    if (beat_q.size() != NB || bad != 0) begin
      errors++; $display("FAIL load_during_stream: got %0d beats %0d bad expected %0d beats 0 bad",
                         beat_q.size(), bad, NB);
    end
  endtask

  task automatic test_addr_oob();
    int c;
    int at;
    int bad;
    load_pixel(9, 16'hEEEE);
    load_pixel(15, 16'hDDDD);
    clear_log();
    start_stream(1'b1, c);
    wait_ready(NB + 20, at);
    bad = 0;
    for (int b = 0; b < beat_q.size() && b < NB; b++) begin
      if (beat_q[b] !== exp_beat(b)) bad++;
    end
    checks++;
    if (beat_q.size() != NB || bad != 0) begin
      errors++; $display("FAIL addr_oob: got %0d beats %0d bad expected %0d beats 0 bad",
                         beat_q.size(), bad, NB);
    end
  endtask

  task automatic test_reset_mid_stream();
    int c;
    int at;
    int bad;
    clear_log();
    start_stream(1'b1, c);
    for (int i = 0; i < 20 && beat_q.size() < 5; i++) step();
    rst = 1'b0;
    step();
    checks++;
    if (next_we !== 2'b00 || next_start !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got we=%b start=%b expected 00 0",
                         next_we, next_start);
    end
    rst = 1'b1;
    step();
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready: got %b expected 1", ready);
    end
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (beat_q.size() != 5 || start_cyc.size() != 0) begin
      errors++; $display("FAIL rst_mid_abort: got %0d beats %0d starts expected 5 beats 0 starts",
                         beat_q.size(), start_cyc.size());
    end
    clear_log();
    start_stream(1'b1, c);
    wait_ready(NB + 20, at);
    bad = 0;
    for (int b = 0; b < beat_q.size() && b < NB; b++) begin
      if (beat_q[b] !== exp_beat(b)) bad++;
    end
    checks++;
    if (beat_q.size() != NB || bad != 0 || start_cyc.size() != 1) begin
      errors++; $display("FAIL rst_mid_restream: got %0d beats %0d bad %0d starts expected %0d 0 1",
                         beat_q.size(), bad, start_cyc.size(), NB);
    end
  endtask

  task automatic test_go_ignored();
    int c;
    clear_log();
    start_stream(1'b1, c);
    for (int i = 0; i < NB + 25; i++) begin
      step();
      go = (cyc == c + 3) || (cyc == c + NB + 2);
    end
    go = 1'b0;
    checks++;
    if (beat_q.size() != NB) begin
      errors++; $display("FAIL go_ignored_beats: got %0d expected %0d", beat_q.size(), NB);
    end
    checks++;
    if (start_cyc.size() != 1 || start_cyc[0] != c + NB + 2) begin
      errors++; $display("FAIL go_ignored_start: got %0d pulses first at %0d expected 1 at %0d",
                         start_cyc.size(), start_cyc.size() > 0 ? start_cyc[0] : -1, c + NB + 2);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL go_ignored_ready: got %b expected 1", ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_same_cycle_load_go();
    test_wait_ready();
    test_load_during_stream();
    test_addr_oob();
    test_reset_mid_stream();
    test_go_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/layer_stream_tx.md
Name: layer_stream_tx

Overview:
- Transmitter end of the inter-layer write/start interface (ibuf_we / ibuf_wr_data / start / ready).
- Holds one IMG_DIM x IMG_DIM x CHANNELS frame in a local buffer, loaded by a host port.
- On command, streams the frame in raster order, one pixel (all channels) per cycle, into the first layer's input buffer, then pulses start.
- Sits at the head of the layer chain, for example in front of a pool or conv layer.

Parameters:
- DATA_SIZE, 8, bits per channel element.
- CHANNELS, 256, channels per pixel; width of the we mask.
- IMG_DIM, 13, frame width and height in pixels.
- PAD, 1, zero border width, used only when STREAM_PAD_EN is defined.
- ADDR_W, $clog2(IMG_DIM*IMG_DIM), buffer address width (localparam-derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- i_load_we  in  1  write the pixel at i_load_addr; honoured only while o_ready=1.
- i_load_addr  in  ADDR_W  raster pixel index, row*IMG_DIM+col.
- i_load_data  in  DATA_SIZE x [CHANNELS]  pixel data, all channels.
- i_go  in  1  request frame transmission.
- o_ready  out  1  idle: load and go are accepted.
- i_next_ready  in  1  downstream layer can accept a new frame.
- o_next_data  out  DATA_SIZE x [CHANNELS]  streamed pixel, registered.
- o_next_we  out  CHANNELS  per-channel write strobe, registered.
- o_next_start  out  1  one-cycle frame-complete pulse, registered.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; o_ready=1 after the edge.
  - o_next_we=0, o_next_start=0, o_next_data=0, counters=0.
  - Buffer contents are not cleared.
- States: IDLE, WAIT_RDY, STREAM, DRAIN, START.
- IDLE:
  - o_ready=1; i_load_we writes the buffer at this edge.
  - i_go=1 with i_next_ready=1 goes to STREAM; i_go=1 with i_next_ready=0 goes to WAIT_RDY.
  - If i_load_we and i_go arrive in the same cycle, the write completes first and the written pixel is streamed.
- WAIT_RDY: o_ready=0; stay until i_next_ready=1, then go to STREAM.
- STREAM:
  - Issue a synchronous buffer read at address cnt each cycle, cnt = 0..N-1 with N=IMG_DIM^2.
  - On cnt=N-1, go to DRAIN. No per-beat stall: i_next_ready is sampled only at frame start.
- Read pipeline: read data is registered one cycle after the address, so o_next_we is all-ones exactly N consecutive cycles, starting one cycle after entering STREAM.
- DRAIN: the last beat is on the outputs; go to START.
- START: o_next_we=0, o_next_start=1 for exactly one cycle, then go to IDLE.
- Latency: i_go accepted at cycle T gives beats T+2..T+1+N, start at T+2+N, and o_ready=1 at T+3+N.
- o_next_data holds its last value when o_next_we=0. It is don't-care for checking.
- i_load_we while o_ready=0 is ignored: no buffer write.
- i_go while busy is ignored: not queued.
- Reset mid-stream aborts at once: we=0, no start pulse.
- i_load_addr >= N is ignored.

Optional Feature:
- Macro STREAM_PAD_EN.
- Defined:
  - The frame is emitted as (IMG_DIM+2*PAD)^2 beats in raster order.
  - Border beats carry data 0 and no buffer read.
  - A row/col counter pair replaces cnt.
  - Latency scales with the padded beat count.
- Undefined: exactly IMG_DIM^2 beats, no padding logic, PAD unused.

Decomposition:
- Shared package layer_pkg:
  - state enum tx_state_t.
  - pixel_t, an array of CHANNELS x DATA_SIZE.
  - function clog2-based ADDR_W helper.
- Sub-module frame_buf: single-port write, single-port synchronous read RAM of N x pixel_t, 1-cycle read latency.
- FSM and counters stay in layer_stream_tx.

Test Plan:
- IMG_DIM=3, CHANNELS=2: load pixel k = {k, 8'h80+k} for k=0..8, then go with next_ready=1 -> 9 consecutive we=2'b11 beats with data 0..8 in order, start pulse one cycle after beat 8, o_ready back next cycle.
- go with next_ready=0 for 5 cycles, then 1 -> no we during wait; stream begins 1 cycle after ready rises; beat count is 9.
- i_load_we asserted during STREAM at addr 4 with data 0xFF -> buffer unchanged; a second go re-streams the original value 4.
- rst=0 asserted at beat 4 -> we=0 and start=0 from the next edge; o_ready=1 after release; a new go streams the full 9 beats.
- i_go pulsed during STREAM and START -> ignored; exactly one start pulse per accepted go.
- With STREAM_PAD_EN, PAD=1, IMG_DIM=3 -> 25 beats; beats 0-5, 9, 10, 14, 15, 19-24 carry 0; beats 6-8, 11-13, 16-18 carry loaded pixels 0..8.
